// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the programmable sequence detector.
// State encoding, completion status codes and default parameter values.
package seq_ctrl_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TO_W    = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    localparam logic [1:0] ST_TARGET  = 2'b00;
    localparam logic [1:0] ST_ABORT   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/seq_shift_matcher.sv
// Serial history shifter with fill tracking and a length-masked
// pattern compare against the bit about to be shifted in.
module seq_shift_matcher
    import seq_ctrl_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(DEF_MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               overlap,
    input  logic               data_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               match,
    output logic [LEN_W-1:0]   fill
);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_d;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_d;
    logic [LEN_W:0]     fill_inc;

    always_comb begin
        hist_nxt = {hist_q[MAX_LEN-2:0], data_in};
        fill_inc = {1'b0, fill_q} + (LEN_W + 1)'(1);
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len));
        end
        // compare includes the incoming bit, so a match is seen in its own cycle
        match = shift_en
              && (fill_inc >= {1'b0, len})
              && (((hist_nxt ^ pattern) & len_mask) == '0);
    end

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            hist_d = hist_nxt;
            if (match && !overlap) begin
                fill_d = '0;
            end else if (fill_inc >= (LEN_W + 1)'(MAX_LEN)) begin
                fill_d = LEN_W'(MAX_LEN);
            end else begin
                fill_d = fill_inc[LEN_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign fill = fill_q;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Arm/configure/sequence controller around seq_shift_matcher.
// Optional idle timeout: define SEQ_DETECT_CTRL_TIMEOUT_EN.
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TO_W    = DEF_TO_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic [CNT_W-1:0]               cfg_target,
    input  logic                           cfg_overlap,
    input  logic [TO_W-1:0]                timeout_limit,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           data_valid,
    input  logic                           data_in,
    output logic                           busy,
    output logic                           match_pulse,
    output logic [CNT_W-1:0]               match_count,
    output logic                           done_valid,
    input  logic                           done_ready,
    output logic [1:0]                     done_status
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    state_e             state_q;
    state_e             state_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [MAX_LEN-1:0] pat_d;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_d;
    logic [CNT_W-1:0]   tgt_q;
    logic [CNT_W-1:0]   tgt_d;
    logic               ovl_q;
    logic               ovl_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               pulse_q;
    logic               pulse_d;
    logic [1:0]         status_q;
    logic [1:0]         status_d;

    logic               cfg_ok;
    logic               clear;
    logic               shift_en;
    logic               hit;
    logic [LEN_W-1:0]   fill_unused;

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    logic [TO_W-1:0]    to_cnt_q;
    logic [TO_W-1:0]    to_cnt_d;
    logic [TO_W-1:0]    to_inc;
`else
    logic               unused_timeout;
    assign unused_timeout = ^timeout_limit;
`endif

    seq_shift_matcher #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_matcher (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .shift_en (shift_en),
        .overlap  (ovl_q),
        .data_in  (data_in),
        .pattern  (pat_q),
        .len      (len_q),
        .match    (hit),
        .fill     (fill_unused)
    );

    assign cfg_ok = (len_q != '0)
                 && (len_q <= LEN_W'(MAX_LEN))
                 && (tgt_q != '0);
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign shift_en = (state_q == S_ARMED) && data_valid;

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        tgt_d    = tgt_q;
        ovl_d    = ovl_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        status_d = status_q;
        clear    = 1'b0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        to_inc   = to_cnt_q + TO_W'(1);
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    pat_d = cfg_pattern;
                    len_d = cfg_len;
                    tgt_d = cfg_target;
                    ovl_d = cfg_overlap;
                end
                // legality is judged on the stored config, not this cycle's write
                if (start && cfg_ok) begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                    clear   = 1'b1;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            S_ARMED: begin
                if (abort) begin
                    state_d  = S_DONE;
                    status_d = ST_ABORT;
                end else if (hit) begin
                    pulse_d = 1'b1;
                    cnt_d   = cnt_inc;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                    if (cnt_inc == tgt_q) begin
                        state_d  = S_DONE;
                        status_d = ST_TARGET;
                    end
                end else begin
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
                    to_cnt_d = to_inc;
                    if ((timeout_limit != '0) && (to_inc == timeout_limit)) begin
                        state_d  = S_DONE;
                        status_d = ST_TIMEOUT;
                    end
`endif
                end
            end
            S_DONE: begin
                if (done_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pat_q    <= '0;
            len_q    <= '0;
            tgt_q    <= '0;
            ovl_q    <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            status_q <= ST_TARGET;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            tgt_q    <= tgt_d;
            ovl_q    <= ovl_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            status_q <= status_d;
        end
    end

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign busy        = (state_q == S_ARMED) || (state_q == S_DONE);
    assign done_valid  = (state_q == S_DONE);
    assign done_status = status_q;
    assign match_pulse = pulse_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Randomized + directed bench for seq_detect_ctrl against a queue-based
// reference model of the detector rules.
module tb_seq_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int TO_W    = 16;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic [CNT_W-1:0]   cfg_target;
    logic               cfg_overlap;
    logic [TO_W-1:0]    timeout_limit;
    logic               start;
    logic               abort;
    logic               data_valid;
    logic               data_in;
    logic               busy;
    logic               match_pulse;
    logic [CNT_W-1:0]   match_count;
    logic               done_valid;
    logic               done_ready;
    logic [1:0]         done_status;

    always #5 clk = ~clk;

    seq_detect_ctrl #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W),
        .TO_W    (TO_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_pattern   (cfg_pattern),
        .cfg_len       (cfg_len),
        .cfg_target    (cfg_target),
        .cfg_overlap   (cfg_overlap),
        .timeout_limit (timeout_limit),
        .start         (start),
        .abort         (abort),
        .data_valid    (data_valid),
        .data_in       (data_in),
        .busy          (busy),
        .match_pulse   (match_pulse),
        .match_count   (match_count),
        .done_valid    (done_valid),
        .done_ready    (done_ready),
        .done_status   (done_status)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model: 0 idle, 1 scanning, 2 reporting
    int                 m_state;
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    int                 m_tgt;
    bit                 m_ovl;
    bit                 m_bits[$];
    int                 m_cnt;
    bit                 m_pulse;
    int                 m_status;
    int                 m_to;

    task automatic model_reset();
        m_state  = 0;
        m_pat    = '0;
        m_len    = 0;
        m_tgt    = 0;
        m_ovl    = 0;
        m_bits.delete();
        m_cnt    = 0;
        m_pulse  = 0;
        m_status = 0;
        m_to     = 0;
    endtask

    function automatic bit pat_hit();
        int n;
        n = m_bits.size();
        if (n < m_len) return 0;
        for (int i = 0; i < m_len; i++) begin
            if (m_bits[n - m_len + i] != m_pat[m_len - 1 - i]) return 0;
        end
        return 1;
    endfunction

    task automatic model_step();
        bit legal;
        bit hit;
        if (rst) begin
            model_reset();
            return;
        end
        legal   = (m_len >= 1) && (m_len <= MAX_LEN) && (m_tgt != 0);
        hit     = 0;
        m_pulse = 0;
        case (m_state)
            0: begin
                if (start && legal) begin
                    m_state = 1;
                    m_cnt   = 0;
                    m_to    = 0;
                    m_bits.delete();
                end
                if (cfg_we) begin
                    m_pat = cfg_pattern;
                    m_len = int'(cfg_len);
                    m_tgt = int'(cfg_target);
                    m_ovl = cfg_overlap;
                end
            end
            1: begin
                if (abort) begin
                    m_state  = 2;
                    m_status = 1;
                end else begin
                    if (data_valid) begin
                        m_bits.push_back(data_in);
                        if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
                        hit = pat_hit();
                    end
                    if (hit) begin
                        m_pulse = 1;
                        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
                        m_to    = 0;
                        if (!m_ovl) m_bits.delete();
                        if (m_cnt == m_tgt) begin
                            m_state  = 2;
                            m_status = 0;
                        end
                    end
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
                    else begin
                        m_to++;
                        if (timeout_limit != 0 && m_to == int'(timeout_limit)) begin
                            m_state  = 2;
                            m_status = 2;
                        end
                    end
`endif
                end
            end
            default: begin
                if (done_ready) m_state = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        check("busy", 32'(busy), 32'(m_state != 0));
        check("pulse", 32'(match_pulse), 32'(m_pulse));
        check("count", 32'(match_count), 32'(m_cnt));
        check("dvalid", 32'(done_valid), 32'(m_state == 2));
        check("status", 32'(done_status), 32'(m_status));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_in();
        cfg_we        = 0;
        cfg_pattern   = '0;
        cfg_len       = '0;
        cfg_target    = '0;
        cfg_overlap   = 0;
        start         = 0;
        abort         = 0;
        data_valid    = 0;
        data_in       = 0;
        done_ready    = 0;
    endtask

    task automatic cfg(input logic [MAX_LEN-1:0] p, input int l,
                       input int t, input bit o);
        cfg_we      = 1;
        cfg_pattern = p;
        cfg_len     = LEN_W'(l);
        cfg_target  = CNT_W'(t);
        cfg_overlap = o;
        tick();
        cfg_we      = 0;
    endtask

    task automatic arm();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic feed(input bit b);
        data_valid = 1;
        data_in    = b;
        tick();
        data_valid = 0;
    endtask

    task automatic drain();
        done_ready = 1;
        tick();
        done_ready = 0;
    endtask

    task automatic settle();
        for (int i = 0; i < 200 && m_state != 0; i++) begin
            done_ready = (m_state == 2);
            abort      = (m_state == 1);
            tick();
        end
        idle_in();
        check("settle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] s1;
        int         idx;
        idle_in();
        timeout_limit = '0;
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 0;

        // start with reset (illegal) config
        arm();
        check("rst_cfg_start", 32'(busy), 32'd0);

        // overlapping 1010, target 2
        cfg(8'b1010, 4, 2, 1);
        arm();
        s1 = 8'b101010;
        for (int i = 0; i < 6; i++) begin
            feed(s1[5 - i]);
            if (i == 3) check("t1_p4", 32'(match_pulse), 32'd1);
        end
        check("t1_cnt", 32'(match_count), 32'd2);
        check("t1_dv", 32'(done_valid), 32'd1);
        check("t1_st", 32'(done_status), 32'd0);
        drain();

        // non-overlapping: second hit needs four fresh bits
        cfg(8'b1010, 4, 2, 0);
        arm();
        for (int i = 0; i < 8; i++) begin
            feed(i % 2 == 0);
            if (i == 5) check("t2_p6", 32'(match_pulse), 32'd0);
        end
        check("t2_p8", 32'(match_pulse), 32'd1);
        check("t2_st", 32'(done_status), 32'd0);
        drain();

        // abort beats a same-cycle match
        cfg(8'b110, 3, 5, 0);
        arm();
        for (int i = 0; i < 8; i++) feed(i % 3 != 2);
        abort = 1;
        feed(0);
        abort = 0;
        check("t3_pulse", 32'(match_pulse), 32'd0);
        check("t3_cnt", 32'(match_count), 32'd2);
        check("t3_st", 32'(done_status), 32'd1);

        // status held while host stalls
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold", 32'(done_status), 32'd1);
        end
        done_ready = 1;
        start      = 1;
        tick();
        done_ready = 0;
        start      = 0;
        check("t4_idle", 32'(busy), 32'd0);
        tick();
        check("t4_nostart", 32'(busy), 32'd0);
        check("t4_cnt_hold", 32'(match_count), 32'd2);

        // illegal configs and writes during scan
        cfg(8'b101, 0, 2, 0);
        arm();
        check("t5_len0", 32'(busy), 32'd0);
        cfg(8'b101, 3, 0, 0);
        arm();
        check("t5_tgt0", 32'(busy), 32'd0);
        cfg(8'b110, 3, 1, 0);
        arm();
        cfg(8'b11, 2, 3, 1);
        feed(1);
        feed(1);
        check("t5_nocfg", 32'(match_pulse), 32'd0);
        feed(0);
        check("t5_hit", 32'(match_count), 32'd1);
        check("t5_st", 32'(done_status), 32'd0);
        drain();

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
        timeout_limit = 16'd20;
        cfg(8'b111, 3, 1, 0);
        arm();
        repeat (19) tick();
        check("t6_pre", 32'(done_valid), 32'd0);
        tick();
        check("t6_to", 32'(done_status), 32'd2);
        drain();
        timeout_limit = '0;
`endif

        // reset mid-scan
        cfg(8'b1011, 4, 3, 1);
        arm();
        for (int i = 0; i < 5; i++) feed(i[0]);
        #2;
        rst = 1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(match_count), 32'd0);
        check("rst_dv", 32'(done_valid), 32'd0);
        tick();
        rst = 0;
        tick();

        // random episodes
        for (int ep = 0; ep < 40; ep++) begin
            cfg(MAX_LEN'($urandom), $urandom_range(0, MAX_LEN),
                ($urandom % 6 == 0) ? 0 : $urandom_range(1, 4),
                bit'($urandom % 2));
            arm();
            idx = 0;
            for (int c = 0; c < 120; c++) begin
                data_valid = ($urandom % 4) != 0;
                if (m_len > 0 && ($urandom % 3) != 0) begin
                    data_in = m_pat[m_len - 1 - (idx % m_len)];
                    idx++;
                end else begin
                    data_in = 1'($urandom);
                end
                abort      = ($urandom % 60) == 0;
                done_ready = ($urandom % 3) == 0;
                start      = ($urandom % 6) == 0;
                cfg_we     = ($urandom % 12) == 0;
                cfg_pattern = MAX_LEN'($urandom);
                cfg_len     = LEN_W'($urandom_range(1, MAX_LEN));
                cfg_target  = CNT_W'($urandom_range(1, 3));
                cfg_overlap = 1'($urandom);
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
                if (c == 0) timeout_limit = TO_W'($urandom_range(0, 40));
`endif
                tick();
            end
            idle_in();
            settle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
